// File: rtl/sort_array_drain.sv
// rtl/sort_array_drain.sv - read-out/drain controller for the systolic sorting array
//
// Freezes the sorter chain, snapshots every cell, then streams the occupied
// prefix of the chain (cell 0 = highest key) over a valid/ready interface.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           drain request, only honoured in IDLE
//   cell_data_bus   32 bits per cell, cell i on [32*i+31:32*i]
//   cell_state_bus  1 = cell occupied, cell i on bit i
//   sort_en         enable to the sorting cells, low for the whole drain
//   array_clr       one-cycle clear request to the array
//   out_data/out_valid/out_ready/out_last   sorted output stream
//   busy            high outside IDLE
//   done            one-cycle end-of-drain pulse
//   empty_drain     qualified by done: the drain found no entries
//   count           entries captured by the last snapshot
//   order_err       sticky descending-order violation flag
//
// Optional feature macro: SORT_DRAIN_ORDER_CHECK_EN (order_err comparator).
// Without it order_err is tied low.

module sort_array_drain #(
    parameter int N_CELLS        = 8,
    parameter int CLEAR_ON_DRAIN = 1,
    parameter int CNT_W          = $clog2(N_CELLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*N_CELLS-1:0] cell_data_bus,
    input  logic [N_CELLS-1:0]    cell_state_bus,
    output logic                  sort_en,
    output logic                  array_clr,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  empty_drain,
    output logic [CNT_W-1:0]      count,
    output logic                  order_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_LOAD,
        S_SEND,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       shadow [N_CELLS];
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  load_count;
    logic              found_empty;
    logic              empty_flag;
    logic [31:0]       cur_word;
    logic              is_last;
    logic              handshake;

    // Occupancy is a contiguous prefix: the first empty cell ends it, and
    // anything marked occupied beyond that point is stale and ignored.
    always_comb begin
        load_count  = CNT_W'(N_CELLS);
        found_empty = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (!found_empty && !cell_state_bus[i]) begin
                load_count  = CNT_W'(i);
                found_empty = 1'b1;
            end
        end
    end

    // Explicit compare-mux rather than shadow[idx]: idx is one bit wider
    // than the array index so it can also hold N_CELLS as a count.
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (idx == CNT_W'(i)) begin
                cur_word = shadow[i];
            end
        end
    end

    assign is_last   = (idx == count - CNT_W'(1));
    assign handshake = (state == S_SEND) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FREEZE;
            S_FREEZE: state_nxt = S_LOAD;
            S_LOAD:   state_nxt = (load_count == '0) ? S_DONE : S_SEND;
            S_SEND: begin
                if (out_ready && is_last) begin
                    state_nxt = (CLEAR_ON_DRAIN != 0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            count      <= '0;
            empty_flag <= 1'b0;
            for (int i = 0; i < N_CELLS; i++) begin
                shadow[i] <= '0;
            end
        end else if (state == S_LOAD) begin
            idx        <= '0;
            count      <= load_count;
            empty_flag <= (load_count == '0);
            for (int i = 0; i < N_CELLS; i++) begin
                shadow[i] <= cell_data_bus[32*i +: 32];
            end
        end else if (handshake && !is_last) begin
            idx <= idx + CNT_W'(1);
        end
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // returns them to their idle values immediately. An empty drain skips
    // CLEAR to keep done at T+3, so its clear pulse rides with done instead.
    assign sort_en     = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = (state == S_SEND);
    assign out_data    = (state == S_SEND) ? cur_word : 32'd0;
    assign out_last    = (state == S_SEND) && is_last;
    assign done        = (state == S_DONE);
    assign empty_drain = (state == S_DONE) && empty_flag;
    assign array_clr   = (state == S_CLEAR) ||
                         ((CLEAR_ON_DRAIN != 0) && (state == S_DONE) && empty_flag);

`ifdef SORT_DRAIN_ORDER_CHECK_EN
    logic [31:0] prev_word;
    logic        order_err_q;

    always_comb begin
        prev_word = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (idx == CNT_W'(i + 1)) begin
                prev_word = shadow[i];
            end
        end
    end

    // Only the 20-bit key takes part; equal keys are a legal ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            order_err_q <= 1'b0;
        end else if (handshake && idx != '0 && cur_word[19:0] > prev_word[19:0]) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule
